character_motion_ctrl: RTL and testbench
========================================

CHARACTER_MOTION_CTRL -- requirements
Module: character_motion_ctrl

Interface
REQ-001 SHALL have parameter SPAWN_X, default 800, spawn left x coordinate in px.
REQ-002 SHALL have parameter SPAWN_Y, default 719 (FLOOR_Y-CHAR_H), spawn upper y coordinate in px.
REQ-003 SHALL have parameter CHAR_W, default 32, sprite width; parameter CHAR_H, default 48, sprite height.
REQ-004 SHALL have parameter SCREEN_W, default 1024, and parameter FLOOR_Y, default 767, the lowest y the sprite bottom may reach.
REQ-005 SHALL have parameter JUMP_HEIGHT, default 200, maximum rise in px per jump.
REQ-006 SHALL have parameters X_TICKS 400000 (ground step period), X_AIR_TICKS 700000 (air step period) and FALL_TICKS 150000 (fall step period).
REQ-007 SHALL have parameters JUMP_TICKS_START 200000, JUMP_TICKS_STEP 40000 and JUMP_TICKS_MAX 800000 (jump deceleration).
REQ-008 SHALL have parameter ANIM_FRAMES, default 8, walk frame count, range 1..16.
REQ-009 clk  input  1  system clock, the single clock.
REQ-010 rst  input  1  reset, synchronous and active-high.
REQ-011 left, right, jump  input  1 each  level-sensitive player controls.
REQ-012 on_ground  input  1  external platform checker: sprite bottom rests on a platform.
REQ-013 head_hit  input  1  external platform checker: sprite top touches a platform underside.
REQ-014 respawn  input  1  single-cycle request to return to the spawn point.
REQ-015 x, y  output  10 each  registered upper-left sprite coordinate.
REQ-016 sprite_control  output  7  {dir(1=right), air, idle, frame[3:0]}.
REQ-017 state  output  3  current FSM state code.

Function
REQ-018 FSM states SHALL be SPAWN=0, IDLE=1, MOVING=2, JUMPING=3, FALLING=4; all other codes SHALL go to SPAWN.
REQ-019 SPAWN SHALL load x=SPAWN_X, y=SPAWN_Y, sprite_control=7'b1010000 and go to IDLE in the next cycle.
REQ-020 Horizontal step: only one of left/right active -> counter increments; at counter>=period, x moves 1 px, counter clears; so one step per period+1 cycles.
REQ-021 Both or neither of left/right active SHALL clear the horizontal counter and hold x and dir.
REQ-022 x SHALL be clamped to 0..SCREEN_W-CHAR_W and y to 0..FLOOR_Y-CHAR_H after every update.
REQ-023 jump SHALL be edge-detected: only a 0->1 transition (registered previous value) starts a jump.
REQ-024 IDLE: jump edge -> JUMPING (priority); else exactly one direction -> MOVING; else stay, with sprite_control={dir,0,1,0000}.
REQ-025 MOVING: period X_TICKS; frame advances (mod ANIM_FRAMES) on a step when x[2:0]==0 before the step; air=0, idle=0.
REQ-026 MOVING exits: jump edge -> JUMPING; no direction -> IDLE; !on_ground and sprite not at floor -> FALLING.
REQ-027 Entering JUMPING SHALL latch y_start=y and reset jump_stop=JUMP_TICKS_START.
REQ-028 JUMPING: y decrements when vertical counter>=jump_stop; jump_stop then increases by JUMP_TICKS_STEP, saturating at JUMP_TICKS_MAX.
REQ-029 JUMPING -> FALLING when y_start-y>=JUMP_HEIGHT, head_hit=1, or y==0, checked every cycle.
REQ-030 FALLING: y increments every FALL_TICKS+1 cycles; -> IDLE when on_ground=1 or y==FLOOR_Y-CHAR_H.
REQ-031 JUMPING/FALLING horizontal period SHALL be X_AIR_TICKS in both directions; frame advances on every step; air=1.
REQ-032 Vertical counter SHALL clear on every state change.
REQ-033 respawn SHALL force SPAWN from any state, overriding all other inputs.

Reset
REQ-034 rst SHALL set state=SPAWN, x=0, y=0, sprite_control=0, and clear all counters, y_start and the jump edge register.
REQ-035 rst asserted mid-jump SHALL abort the jump; after release, outputs SHALL equal spawn values after two cycles.

Configuration
REQ-036 Macro DOUBLE_JUMP_EN defined: one jump edge while in JUMPING or FALLING restarts the jump (per REQ-027); the air-jump credit is restored on landing or SPAWN.
REQ-037 DOUBLE_JUMP_EN undefined: jump edges in JUMPING/FALLING SHALL be ignored.

Verification
REQ-038 rst 3 cycles, release -> cycle 1 x=0,y=0,state=SPAWN; cycle 2 x=800,y=719,sprite_control=7'b1010000,state=IDLE.
REQ-039 X_TICKS=3, right held 40 cycles from IDLE at x=800 -> x=809 after 40 cycles, dir=1, frame increments once at x=800->801 and once at x=808->809.
REQ-040 Left and right held together in MOVING -> x constant, counter 0, state IDLE next cycle.
REQ-041 JUMP_HEIGHT=4, jump pulse, on_ground=0 until return -> y falls 719->715, FALLING entered, then IDLE at y=719.
REQ-042 Jump held high continuously after landing -> no second jump until jump drops to 0 and rises again.
REQ-043 DOUBLE_JUMP_EN defined, second jump edge in FALLING at y=716 -> y_start=716, state=JUMPING; third edge ignored.

Source files
------------

// File: rtl/character_motion_ctrl.sv
// Platformer character motion FSM: walk, jump and fall with registered sprite control.
// Optional DOUBLE_JUMP_EN grants one air jump per landing or spawn.
module character_motion_ctrl #(
   parameter int unsigned SPAWN_X          = 800,
   parameter int unsigned SPAWN_Y          = 719,
   parameter int unsigned CHAR_W           = 32,
   parameter int unsigned CHAR_H           = 48,
   parameter int unsigned SCREEN_W         = 1024,
   parameter int unsigned FLOOR_Y          = 767,
   parameter int unsigned JUMP_HEIGHT      = 200,
   parameter int unsigned X_TICKS          = 400000,
   parameter int unsigned X_AIR_TICKS      = 700000,
   parameter int unsigned FALL_TICKS       = 150000,
   parameter int unsigned JUMP_TICKS_START = 200000,
   parameter int unsigned JUMP_TICKS_STEP  = 40000,
   parameter int unsigned JUMP_TICKS_MAX   = 800000,
   parameter int unsigned ANIM_FRAMES      = 8
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       left_i,
   input  logic       right_i,
   input  logic       jump_i,
   input  logic       on_ground_i,
   input  logic       head_hit_i,
   input  logic       respawn_i,
   output logic [9:0] x_o,
   output logic [9:0] y_o,
   output logic [6:0] sprite_control_o,
   output logic [2:0] state_o
);

   localparam int unsigned CW   = 24;
   localparam logic [9:0]  XMAX = 10'(SCREEN_W - CHAR_W);
   localparam logic [9:0]  YMAX = 10'(FLOOR_Y - CHAR_H);
   localparam logic [9:0]  SPX  = (SPAWN_X > SCREEN_W - CHAR_W) ? XMAX : 10'(SPAWN_X);
   localparam logic [9:0]  SPY  = (SPAWN_Y > FLOOR_Y - CHAR_H) ? YMAX : 10'(SPAWN_Y);

   typedef enum logic [2:0] {
      StSpawn   = 3'd0,
      StIdle    = 3'd1,
      StMoving  = 3'd2,
      StJumping = 3'd3,
      StFalling = 3'd4
   } state_e;

   state_e        state_q, state_d;
   logic [9:0]    x_q, x_d, y_q, y_d, ystart_q, ystart_d;
   logic [6:0]    sc_q, sc_d;
   logic [CW-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d, jstop_q, jstop_d;
   logic [CW-1:0] period;
   logic          jump_q, jump_edge, one_dir, in_air, air_jump, step, dir, start_jump;
   logic [3:0]    frame;

   assign jump_edge = jump_i & ~jump_q;
   assign one_dir   = left_i ^ right_i;
   assign in_air    = (state_q == StJumping) || (state_q == StFalling);
   assign period    = (state_q == StMoving) ? CW'(X_TICKS) : CW'(X_AIR_TICKS);

`ifdef DOUBLE_JUMP_EN
   logic credit_q, credit_d;
   assign air_jump = jump_edge & credit_q;

   always_comb begin
      credit_d = credit_q;
      if (state_q == StSpawn || (state_q == StFalling && state_d == StIdle)) begin
         credit_d = 1'b1;
      end else if (air_jump && in_air && !respawn_i) begin
         credit_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) credit_q <= 1'b0;
      else       credit_q <= credit_d;
   end
`else
   assign air_jump = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      x_d        = x_q;
      y_d        = y_q;
      ystart_d   = ystart_q;
      hcnt_d     = hcnt_q;
      vcnt_d     = vcnt_q;
      jstop_d    = jstop_q;
      dir        = sc_q[6];
      frame      = sc_q[3:0];
      step       = 1'b0;
      start_jump = 1'b0;
      if (respawn_i) begin
         state_d = StSpawn;
         hcnt_d  = '0;
         vcnt_d  = '0;
      end else begin
         if (state_q inside {StMoving, StJumping, StFalling} && one_dir) begin
            dir = right_i;
            if (hcnt_q >= period) begin
               step   = 1'b1;
               hcnt_d = '0;
            end else begin
               hcnt_d = hcnt_q + CW'(1);
            end
         end else begin
            hcnt_d = '0;
         end
         if (step) begin
            // Walking animates only on 8 px boundaries; airborne animates every step.
            if (in_air || x_q[2:0] == 3'd0) begin
               frame = ({1'b0, frame} + 5'd1 >= 5'(ANIM_FRAMES)) ? 4'd0 : frame + 4'd1;
            end
            if (right_i) x_d = (x_q >= XMAX) ? XMAX : x_q + 10'd1;
            else         x_d = (x_q == 10'd0) ? 10'd0 : x_q - 10'd1;
         end
         case (state_q)
            StSpawn: begin
               x_d     = SPX;
               y_d     = SPY;
               dir     = 1'b1;
               frame   = 4'd0;
               state_d = StIdle;
            end
            StIdle: begin
               frame = 4'd0;
               if (jump_edge) begin
                  start_jump = 1'b1;
               end else if (one_dir) begin
                  dir     = right_i;
                  state_d = StMoving;
               end
            end
            StMoving: begin
               if (jump_edge)                        start_jump = 1'b1;
               else if (!one_dir)                    state_d = StIdle;
               else if (!on_ground_i && y_q != YMAX) state_d = StFalling;
            end
            StJumping: begin
               if (air_jump) begin
                  start_jump = 1'b1;
               end else if ((ystart_q - y_q) >= 10'(JUMP_HEIGHT) || head_hit_i || y_q == 10'd0) begin
                  state_d = StFalling;
               end else if (vcnt_q >= jstop_q) begin
                  y_d     = y_q - 10'd1;
                  vcnt_d  = '0;
                  jstop_d = (jstop_q + CW'(JUMP_TICKS_STEP) >= CW'(JUMP_TICKS_MAX)) ?
                            CW'(JUMP_TICKS_MAX) : jstop_q + CW'(JUMP_TICKS_STEP);
               end else begin
                  vcnt_d = vcnt_q + CW'(1);
               end
            end
            StFalling: begin
               if (air_jump) begin
                  start_jump = 1'b1;
               end else if (on_ground_i || y_q == YMAX) begin
                  state_d = StIdle;
               end else if (vcnt_q >= CW'(FALL_TICKS)) begin
                  y_d    = (y_q >= YMAX) ? YMAX : y_q + 10'd1;
                  vcnt_d = '0;
               end else begin
                  vcnt_d = vcnt_q + CW'(1);
               end
            end
            default: state_d = StSpawn;
         endcase
         if (start_jump) begin
            state_d  = StJumping;
            ystart_d = y_q;
            jstop_d  = CW'(JUMP_TICKS_START);
            vcnt_d   = '0;
         end
         if (state_d != state_q) vcnt_d = '0;
      end
      case (state_d)
         StIdle:               sc_d = {dir, 2'b01, 4'd0};
         StMoving:             sc_d = {dir, 2'b00, frame};
         StJumping, StFalling: sc_d = {dir, 2'b10, frame};
         default:              sc_d = sc_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= StSpawn;
         x_q      <= '0;
         y_q      <= '0;
         ystart_q <= '0;
         sc_q     <= '0;
         hcnt_q   <= '0;
         vcnt_q   <= '0;
         jstop_q  <= '0;
         jump_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         y_q      <= y_d;
         ystart_q <= ystart_d;
         sc_q     <= sc_d;
         hcnt_q   <= hcnt_d;
         vcnt_q   <= vcnt_d;
         jstop_q  <= jstop_d;
         jump_q   <= jump_i;
      end
   end

   assign x_o              = x_q;
   assign y_o              = y_q;
   assign sprite_control_o = sc_q;
   assign state_o          = state_q;

endmodule

// File: tb/tb_character_motion_ctrl.sv
// Self-checking bench for character_motion_ctrl: vector table, corner sequences and a
// randomized run against a behavioural model. Honours DOUBLE_JUMP_EN when defined.
module tb_character_motion_ctrl;

   localparam int XT = 3, XAT = 5, FT = 2, JS = 1, JSTEP = 1, JMAX = 3, JH = 4, FR = 8;
   localparam int XMAX = 992, YMAX = 719, SPX = 800, SPY = 719;
`ifdef DOUBLE_JUMP_EN
   localparam bit DJ = 1'b1;
`else
   localparam bit DJ = 1'b0;
`endif

   logic       clk = 1'b0, rst = 1'b1;
   logic       left = 1'b0, right = 1'b0, jump = 1'b0, on_ground = 1'b1;
   logic       head_hit = 1'b0, respawn = 1'b0;
   logic [9:0] x_o, y_o;
   logic [6:0] sc_o;
   logic [2:0] state_o;

   int n_checks = 0, n_errors = 0;

   character_motion_ctrl #(
      .X_TICKS(XT), .X_AIR_TICKS(XAT), .FALL_TICKS(FT), .JUMP_TICKS_START(JS),
      .JUMP_TICKS_STEP(JSTEP), .JUMP_TICKS_MAX(JMAX), .JUMP_HEIGHT(JH)
   ) dut (
      .clk_i(clk), .rst_i(rst), .left_i(left), .right_i(right), .jump_i(jump),
      .on_ground_i(on_ground), .head_hit_i(head_hit), .respawn_i(respawn),
      .x_o(x_o), .y_o(y_o), .sprite_control_o(sc_o), .state_o(state_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [5:0] stim;  // {left, right, jump, on_ground, head_hit, respawn}
      int         n;
      int         ex, ey, est;
      logic [6:0] esc;
   } vec_t;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         if (n_errors <= 25) $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      {left, right, jump, on_ground, head_hit, respawn} = 6'b000100;
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
   endtask

   task automatic wait_state(input int st, input int budget, input string nm);
      int k = 0;
      while (int'(state_o) != st && k < budget) begin
         tick();
         k++;
      end
      check(nm, int'(state_o), st);
   endtask

   task automatic wait_y(input int yv, input int budget, input string nm);
      int k = 0;
      while (int'(y_o) != yv && k < budget) begin
         tick();
         k++;
      end
      check(nm, int'(y_o), yv);
   endtask

   // Behavioural model state
   int m_x, m_y, m_st, m_dir, m_frame, m_sc, m_h, m_v, m_stop, m_ys, m_jp, m_cred;

   function automatic int clampi(input int v, input int lo, input int hi);
      return (v < lo) ? lo : ((v > hi) ? hi : v);
   endfunction

   task automatic model_step(input int l, input int r, input int j, input int g,
                             input int hh, input int rs);
      int  nst, per;
      bit  edge_j, one, go_jump;
      edge_j  = (j != 0) && (m_jp == 0);
      one     = (l != r);
      nst     = m_st;
      go_jump = 1'b0;
      if (rs != 0) begin
         nst = 0;
         m_h = 0;
         m_v = 0;
      end else begin
         if (m_st >= 2 && m_st <= 4 && one) begin
            per   = (m_st == 2) ? XT : XAT;
            m_dir = r;
            if (m_h >= per) begin
               m_h = 0;
               if (m_st != 2 || m_x % 8 == 0) m_frame = (m_frame + 1) % FR;
               m_x = clampi(m_x + ((r != 0) ? 1 : -1), 0, XMAX);
            end else begin
               m_h++;
            end
         end else begin
            m_h = 0;
         end
         case (m_st)
            0: begin
               m_x = SPX; m_y = SPY; m_dir = 1; m_frame = 0; nst = 1; m_cred = 1;
            end
            1: begin
               if (edge_j) go_jump = 1'b1;
               else if (one) begin nst = 2; m_dir = r; end
            end
            2: begin
               if (edge_j) go_jump = 1'b1;
               else if (!one) nst = 1;
               else if (g == 0 && m_y != YMAX) nst = 4;
            end
            3, 4: begin
               if (DJ && edge_j && m_cred != 0) begin
                  go_jump = 1'b1;
                  m_cred  = 0;
               end else if (m_st == 3) begin
                  if (m_ys - m_y >= JH || hh != 0 || m_y == 0) nst = 4;
                  else if (m_v >= m_stop) begin
                     m_y = clampi(m_y - 1, 0, YMAX); m_v = 0;
                     m_stop = (m_stop + JSTEP > JMAX) ? JMAX : m_stop + JSTEP;
                  end else m_v++;
               end else begin
                  if (g != 0 || m_y == YMAX) begin nst = 1; m_cred = 1; end
                  else if (m_v >= FT) begin m_y = clampi(m_y + 1, 0, YMAX); m_v = 0; end
                  else m_v++;
               end
            end
            default: nst = 0;
         endcase
         if (go_jump) begin
            nst = 3; m_ys = m_y; m_stop = JS; m_v = 0;
         end
         if (nst != m_st) m_v = 0;
      end
      m_jp = j;
      m_st = nst;
      if (nst == 1) m_frame = 0;
      case (nst)
         1:       m_sc = m_dir * 64 + 16;
         2:       m_sc = m_dir * 64 + m_frame;
         3, 4:    m_sc = m_dir * 64 + 32 + m_frame;
         default: ;
      endcase
   endtask

   vec_t vecs[$];

   initial begin
      int l, r, j, g, hh, rs;

      vecs.push_back('{6'b000100, 1, 800, 719, 1, 7'b1010000});
      vecs.push_back('{6'b010100, 1, 800, 719, 2, 7'b1000000});
      vecs.push_back('{6'b010100, 3, 800, 719, 2, 7'b1000000});
      vecs.push_back('{6'b010100, 1, 801, 719, 2, 7'b1000001});
      vecs.push_back('{6'b110100, 1, 801, 719, 1, 7'b1010000});
      vecs.push_back('{6'b100100, 1, 801, 719, 2, 7'b0000000});
      vecs.push_back('{6'b100100, 4, 800, 719, 2, 7'b0000000});
      vecs.push_back('{6'b000100, 1, 800, 719, 1, 7'b0010000});
      vecs.push_back('{6'b001100, 1, 800, 719, 3, 7'b0100000});
      vecs.push_back('{6'b001000, 2, 800, 718, 3, 7'b0100000});
      vecs.push_back('{6'b000000, 3, 800, 717, 3, 7'b0100000});
      vecs.push_back('{6'b000000, 4, 800, 716, 3, 7'b0100000});
      vecs.push_back('{6'b000000, 4, 800, 715, 3, 7'b0100000});
      vecs.push_back('{6'b000000, 1, 800, 715, 4, 7'b0100000});
      vecs.push_back('{6'b000000, 3, 800, 716, 4, 7'b0100000});
      vecs.push_back('{6'b000000, 9, 800, 719, 4, 7'b0100000});
      vecs.push_back('{6'b000000, 1, 800, 719, 1, 7'b0010000});
      vecs.push_back('{6'b010100, 1, 800, 719, 2, 7'b1000000});
      vecs.push_back('{6'b010101, 1, 800, 719, 0, 7'b1000000});
      vecs.push_back('{6'b000100, 1, 800, 719, 1, 7'b1010000});
      vecs.push_back('{6'b001100, 1, 800, 719, 3, 7'b1100000});
      vecs.push_back('{6'b000010, 1, 800, 719, 4, 7'b1100000});
      vecs.push_back('{6'b000000, 1, 800, 719, 1, 7'b1010000});

      // Reset release: reset values first, spawn values one edge later
      do_reset();
      check("rst_x", int'(x_o), 0);
      check("rst_y", int'(y_o), 0);
      check("rst_state", int'(state_o), 0);
      check("rst_sc", int'(sc_o), 0);
      tick();
      check("spawn_x", int'(x_o), 800);
      check("spawn_y", int'(y_o), 719);
      check("spawn_state", int'(state_o), 1);
      check("spawn_sc", int'(sc_o), 7'b1010000);

      foreach (vecs[i]) begin
         {left, right, jump, on_ground, head_hit, respawn} = vecs[i].stim;
         repeat (vecs[i].n) tick();
         check($sformatf("vec%0d_x", i), int'(x_o), vecs[i].ex);
         check($sformatf("vec%0d_y", i), int'(y_o), vecs[i].ey);
         check($sformatf("vec%0d_state", i), int'(state_o), vecs[i].est);
         check($sformatf("vec%0d_sc", i), int'(sc_o), int'(vecs[i].esc));
      end

      // Walk right 40 cycles from spawn, then both directions, then clamp at both edges
      do_reset();
      tick();
      right = 1'b1;
      repeat (40) tick();
      check("walk40_x", int'(x_o), 809);
      check("walk40_sc", int'(sc_o), 7'b1000010);
      left = 1'b1;
      tick();
      check("both_x", int'(x_o), 809);
      check("both_state", int'(state_o), 1);
      left = 1'b0;
      tick();
      repeat (3) tick();
      check("cnt_cleared_x", int'(x_o), 809);
      tick();
      check("cnt_step_x", int'(x_o), 810);
      right = 1'b0;
      left  = 1'b1;
      repeat (3300) tick();
      check("clamp_left_x", int'(x_o), 0);
      check("clamp_left_state", int'(state_o), 2);
      left  = 1'b0;
      right = 1'b1;
      repeat (4100) tick();
      check("clamp_right_x", int'(x_o), XMAX);

      // Held jump must not retrigger after landing
      do_reset();
      tick();
      on_ground = 1'b0;
      jump = 1'b1;
      wait_state(4, 100, "held_fall");
      wait_state(1, 100, "held_land");
      check("held_land_y", int'(y_o), 719);
      repeat (10) tick();
      check("held_no_rejump", int'(state_o), 1);
      jump = 1'b0;
      tick();
      check("held_released", int'(state_o), 1);
      jump = 1'b1;
      tick();
      check("held_new_edge", int'(state_o), 3);

      // Air jump while falling at y=716
      do_reset();
      tick();
      on_ground = 1'b0;
      jump = 1'b1;
      tick();
      jump = 1'b0;
      check("air_jump_start", int'(state_o), 3);
      wait_state(4, 100, "air_fall1");
      wait_y(716, 50, "air_y716");
      jump = 1'b1;
      tick();
`ifdef DOUBLE_JUMP_EN
      check("dj_restart_state", int'(state_o), 3);
      check("dj_restart_y", int'(y_o), 716);
      jump = 1'b0;
      wait_state(4, 100, "dj_fall2");
      check("dj_apex_y", int'(y_o), 712);
      jump = 1'b1;
      tick();
      check("dj_third_ignored", int'(state_o), 4);
`else
      check("air_jump_ignored", int'(state_o), 4);
`endif
      jump = 1'b0;
      wait_state(1, 200, "air_land");
      check("air_land_y", int'(y_o), 719);

      // Reset mid-jump
      do_reset();
      tick();
      on_ground = 1'b0;
      jump = 1'b1;
      repeat (3) tick();
      rst = 1'b1;
      tick();
      check("midrst_state", int'(state_o), 0);
      check("midrst_x", int'(x_o), 0);
      check("midrst_y", int'(y_o), 0);
      check("midrst_sc", int'(sc_o), 0);
      rst  = 1'b0;
      jump = 1'b0;
      repeat (2) tick();
      check("midrst_spawn_x", int'(x_o), 800);
      check("midrst_spawn_y", int'(y_o), 719);
      check("midrst_spawn_state", int'(state_o), 1);
      check("midrst_spawn_sc", int'(sc_o), 7'b1010000);

      // Randomized run against the model
      {left, right, jump, on_ground, head_hit, respawn} = 6'b000100;
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      m_x = 0; m_y = 0; m_st = 0; m_dir = 0; m_frame = 0; m_sc = 0;
      m_h = 0; m_v = 0; m_stop = 0; m_ys = 0; m_jp = 0; m_cred = 0;
      l = 0; r = 0; j = 0; g = 1;
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 15) == 0) l = 1 - l;
         if ($urandom_range(0, 15) == 0) r = 1 - r;
         if ($urandom_range(0, 5) == 0)  j = 1 - j;
         if ($urandom_range(0, 7) == 0)  g = 1 - g;
         hh = ($urandom_range(0, 31) == 0) ? 1 : 0;
         rs = ($urandom_range(0, 199) == 0) ? 1 : 0;
         left = l[0]; right = r[0]; jump = j[0];
         on_ground = g[0]; head_hit = hh[0]; respawn = rs[0];
         model_step(l, r, j, g, hh, rs);
         tick();
         check("rand_x", int'(x_o), m_x);
         check("rand_y", int'(y_o), m_y);
         check("rand_state", int'(state_o), m_st);
         check("rand_sc", int'(sc_o), m_sc);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
